// File: rtl/dmem_responder.sv
// Data-memory responder for the multi-cycle RV32I core: it runs one load/store per transaction, inserts wait states and returns data through a valid/ready handshake.
// Define DMEM_MMIO_EN to add a word-wide output register at MMIO_ADDR (ports mmio_out, mmio_strobe).
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0] mmio_out,
    output logic        mmio_strobe
`endif
);
    localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  LAST_WAIT  = 4'(WAIT_CYCLES);
    localparam bit          NO_WAIT    = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    wait_cnt;
    logic          eval;
    logic          lat_we, lat_unsigned;
    logic [1:0]    lat_size;
    logic [31:0]   lat_addr, lat_wdata;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          ev_we, ev_unsigned;
    logic [1:0]    ev_size;
    logic [31:0]   ev_addr, ev_wdata;
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word, rd_shift, rd_data, wr_data;
    logic [3:0]    wr_be;
    logic          err, mem_we;
`ifdef DMEM_MMIO_EN
    logic          mmio_hit, mmio_we;
`endif

    // Without wait states the request is evaluated from the live inputs on the accept edge.
    assign ev_we       = NO_WAIT ? req_we       : lat_we;
    assign ev_unsigned = NO_WAIT ? req_unsigned : lat_unsigned;
    assign ev_size     = NO_WAIT ? req_size     : lat_size;
    assign ev_addr     = NO_WAIT ? req_addr     : lat_addr;
    assign ev_wdata    = NO_WAIT ? req_wdata    : lat_wdata;

    // NOTE: every signal driven by an always_comb gets a value on every path (defaults first), so no latch is inferred.
    always_comb begin
        state_nxt = state;
        eval      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_nxt = NO_WAIT ? S_RESP : S_WAIT;
                    eval      = NO_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == LAST_WAIT) begin
                    state_nxt = S_RESP;
                    eval      = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        word_idx = ev_addr[AW+1:2];
        lane     = ev_addr[1:0];
        rd_word  = mem[word_idx];
        rd_shift = rd_word >> {lane, 3'b000};
        wr_data  = ev_wdata << {lane, 3'b000};
        err      = (ev_size == 2'b11)
                || (ev_size == 2'b01 && lane[0])
                || (ev_size == 2'b10 && lane != 2'b00)
                || (ev_addr >= BYTE_LIMIT);
        case (ev_size)
            2'b00: begin
                wr_be   = 4'b0001 << lane;
                rd_data = {{24{rd_shift[7] & ~ev_unsigned}}, rd_shift[7:0]};
            end
            2'b01: begin
                wr_be   = 4'b0011 << lane;
                rd_data = {{16{rd_shift[15] & ~ev_unsigned}}, rd_shift[15:0]};
            end
            default: begin
                wr_be   = 4'b1111;
                rd_data = rd_shift;
            end
        endcase
`ifdef DMEM_MMIO_EN
        mmio_hit = (ev_addr == MMIO_ADDR);
        mmio_we  = 1'b0;
        if (mmio_hit) begin
            err     = (ev_size != 2'b10);
            mmio_we = eval && ev_we && !err;
            rd_data = mmio_out;
        end
`endif
        if (err || ev_we) rd_data = '0;
        mem_we = eval && ev_we && !err && reset;
`ifdef DMEM_MMIO_EN
        mem_we = mem_we && !mmio_hit;
`endif
    end

    // NOTE: registers use non-blocking assignments, so every register samples the values present before the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            lat_we       <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
`ifdef DMEM_MMIO_EN
            mmio_out     <= '0;
            mmio_strobe  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && req_valid) begin
                lat_we       <= req_we;
                lat_unsigned <= req_unsigned;
                lat_size     <= req_size;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
                wait_cnt     <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (eval) begin
                rsp_rdata <= rd_data;
                rsp_err   <= err;
            end
`ifdef DMEM_MMIO_EN
            mmio_strobe <= mmio_we;
            if (mmio_we) mmio_out <= ev_wdata;
`endif
        end
    end

    // NOTE: the data array is deliberately left out of reset; its contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: a byte-level memory model is checked every cycle, alongside directed vectors with hand-computed expectations.
module tb_dmem_responder;
    localparam int unsigned DEPTH_WORDS = 256;
    localparam int unsigned WAIT_CYCLES = 2;
    localparam logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0;
    localparam int unsigned BYTES       = 4 * DEPTH_WORDS;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_out;
    logic        mmio_strobe;
`endif

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .WAIT_CYCLES(WAIT_CYCLES),
        .MMIO_ADDR  (MMIO_ADDR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
`ifdef DMEM_MMIO_EN
        ,
        .mmio_out    (mmio_out),
        .mmio_strobe (mmio_strobe)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural model: byte array plus a "response due in N edges" timer.
    logic [7:0]  m_mem [BYTES];
    bit          m_known [BYTES];
    bit          m_busy, m_resp, m_rknown, m_strobe;
    int          m_eta;
    logic [31:0] m_rdata, m_mmio;
    logic        m_err;
    logic        p_we, p_unsigned;
    logic [1:0]  p_size;
    logic [31:0] p_addr, p_wdata;

    function automatic void model_resolve();
        logic [31:0] a;
        logic [31:0] v;
        int          n;
        a = p_addr;
        n = (p_size == 2'd0) ? 1 : (p_size == 2'd1) ? 2 : 4;
        m_err = (p_size == 2'd3) || (p_size == 2'd1 && a[0]) ||
                (p_size == 2'd2 && a[1:0] != 2'd0) || (a >= BYTES);
        m_rdata  = '0;
        m_rknown = 1'b1;
`ifdef DMEM_MMIO_EN
        if (a == MMIO_ADDR) begin
            m_err = (p_size != 2'd2);
            if (!m_err) begin
                if (p_we) begin
                    m_mmio   = p_wdata;
                    m_strobe = 1'b1;
                end else begin
                    m_rdata = m_mmio;
                end
            end
            return;
        end
`endif
        if (m_err) return;
        if (p_we) begin
            for (int i = 0; i < n; i++) begin
                m_mem[int'(a) + i]   = p_wdata[8*i +: 8];
                m_known[int'(a) + i] = 1'b1;
            end
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) begin
                v[8*i +: 8] = m_mem[int'(a) + i];
                if (!m_known[int'(a) + i]) m_rknown = 1'b0;
            end
            if (n == 1 && !p_unsigned) v = {{24{v[7]}}, v[7:0]};
            if (n == 2 && !p_unsigned) v = {{16{v[15]}}, v[15:0]};
            m_rdata = v;
        end
    endfunction

    initial begin
        m_busy = 0; m_resp = 0; m_eta = 0; m_strobe = 0; m_mmio = '0;
        m_rdata = '0; m_err = 1'b0; m_rknown = 1'b0;
        for (int i = 0; i < int'(BYTES); i++) m_known[i] = 1'b0;
        forever begin
            @(posedge clk or negedge reset);
            m_strobe = 1'b0;
            if (!reset) begin
                m_busy = 0;
                m_resp = 0;
            end else if (!m_busy) begin
                if (req_valid) begin
                    m_busy = 1; m_eta = WAIT_CYCLES + 1;
                    p_we = req_we; p_addr = req_addr; p_size = req_size;
                    p_unsigned = req_unsigned; p_wdata = req_wdata;
                end
            end else if (!m_resp) begin
                m_eta--;
                if (m_eta == 0) begin
                    model_resolve();
                    m_resp = 1;
                end
            end else if (rsp_ready) begin
                m_busy = 0;
                m_resp = 0;
            end
        end
    end

    // Compare process: checks the DUT against the model on every falling edge outside reset.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            check("cyc_req_ready", req_ready, !m_busy);
            check("cyc_rsp_valid", rsp_valid, m_resp);
            if (m_resp) begin
                check("cyc_rsp_err", rsp_err, m_err);
                if (m_rknown) check("cyc_rsp_rdata", rsp_rdata, m_rdata);
            end
`ifdef DMEM_MMIO_EN
            check("cyc_mmio_out", mmio_out, m_mmio);
            check("cyc_mmio_strobe", mmio_strobe, m_strobe);
`endif
        end
    end

    task automatic start_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] wdata);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = 32'h0BAD_F00D; req_size = 2'b11;
        req_unsigned = ~uns; req_wdata = ~wdata;
    endtask

    task automatic wait_rsp(input string name);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, 32'd3);
    endtask

    task automatic xact(input string name, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        start_req(we, addr, size, uns, wdata);
        wait_rsp(name);
        check({name, "_err"}, rsp_err, exp_err);
        check({name, "_rdata"}, rsp_rdata, exp_rdata);
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] held;

    initial begin
        req_valid = 0; req_we = 0; req_addr = '0; req_size = '0;
        req_unsigned = 0; req_wdata = '0; rsp_ready = 1;
        repeat (2) @(negedge clk);
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", rsp_err, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        xact("sw_10",   1, 32'h10, 2'b10, 0, 32'hDEAD_BEEF, 32'h0, 0);
        xact("lw_10",   0, 32'h10, 2'b10, 0, 32'h0,         32'hDEAD_BEEF, 0);
        xact("sb_13",   1, 32'h13, 2'b00, 0, 32'h0000_0080, 32'h0, 0);
        xact("lb_13",   0, 32'h13, 2'b00, 0, 32'h0,         32'hFFFF_FF80, 0);
        xact("lbu_13",  0, 32'h13, 2'b00, 1, 32'h0,         32'h0000_0080, 0);
        xact("lw_10b",  0, 32'h10, 2'b10, 0, 32'h0,         32'h80AD_BEEF, 0);
        xact("lh_12",   0, 32'h12, 2'b01, 0, 32'h0,         32'hFFFF_80AD, 0);
        xact("lhu_12",  0, 32'h12, 2'b01, 1, 32'h0,         32'h0000_80AD, 0);
        xact("lw_12",   0, 32'h12, 2'b10, 0, 32'h0,         32'h0, 1);
        xact("sh_11",   1, 32'h11, 2'b01, 0, 32'h0000_1234, 32'h0, 1);
        xact("lw_400",  0, 32'h400, 2'b10, 0, 32'h0,        32'h0, 1);
        xact("sz11",    0, 32'h10, 2'b11, 0, 32'h0,         32'h0, 1);
        xact("lw_10c",  0, 32'h10, 2'b10, 0, 32'h0,         32'h80AD_BEEF, 0);
        xact("sw_3fc",  1, 32'h3FC, 2'b10, 0, 32'hCAFE_F00D, 32'h0, 0);
        xact("lw_3fc",  0, 32'h3FC, 2'b10, 1, 32'h0,        32'hCAFE_F00D, 0);
        xact("sh_3fe",  1, 32'h3FE, 2'b01, 0, 32'hFFFF_1234, 32'h0, 0);
        xact("lw_3fc2", 0, 32'h3FC, 2'b10, 0, 32'h0,        32'h1234_F00D, 0);
        xact("sw_20",   1, 32'h20, 2'b10, 0, 32'h0,         32'h0, 0);

        // Response back-pressure: rsp_rdata must hold while rsp_ready is low.
        rsp_ready = 1'b0;
        start_req(0, 32'h10, 2'b10, 0, 32'h0);
        wait_rsp("stall");
        held = rsp_rdata;
        check("stall_first", held, 32'h80AD_BEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1'b1);
            check("stall_rdata", rsp_rdata, held);
            check("stall_req_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_done_valid", rsp_valid, 1'b0);
        check("stall_done_ready", req_ready, 1'b1);
        @(negedge clk);

        // Reset during WAIT drops the pending store.
        start_req(1, 32'h20, 2'b10, 0, 32'h1234_5678);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        xact("lw_20", 0, 32'h20, 2'b10, 0, 32'h0, 32'h0, 0);
        xact("lw_10d", 0, 32'h10, 2'b10, 0, 32'h0, 32'h80AD_BEEF, 0);

`ifdef DMEM_MMIO_EN
        xact("mmio_sw", 1, MMIO_ADDR, 2'b10, 0, 32'h0000_00A5, 32'h0, 0);
        check("mmio_out_a5", mmio_out, 32'h0000_00A5);
        xact("mmio_lb", 0, MMIO_ADDR, 2'b00, 0, 32'h0, 32'h0, 1);
        xact("mmio_lw", 0, MMIO_ADDR, 2'b10, 0, 32'h0, 32'h0000_00A5, 0);
`else
        xact("mmio_sw", 1, MMIO_ADDR, 2'b10, 0, 32'h0000_00A5, 32'h0, 1);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
